// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared types and constants for the UART transmit arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

   localparam int unsigned c_byte_w = 8;

   // State encoding the FTDI transmitter reports when it is idle.
   localparam logic [1:0] c_tx_idle_state = 2'b00;

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_START     = 2'd1,
      S_WAIT_BUSY = 2'd2,
      S_WAIT_DONE = 2'd3
   } arb_state_t;

   function automatic logic tx_state_busy(input logic [1:0] tx_state);
      return (tx_state != c_tx_idle_state);
   endfunction

endpackage
`default_nettype wire

// File: rtl/rr_picker.sv
`default_nettype none
// ============================================================================
//  Module      : rr_picker
//  Description : Combinational round-robin search starting at rr_ptr+1.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_picker #(
   parameter int N_REQ = 4,
   parameter int ID_W  = 2
) (
   input  logic [N_REQ-1:0] req,
   input  logic [ID_W-1:0]  rr_ptr,
   output logic [ID_W-1:0]  winner,
   output logic             found
);

   logic [ID_W:0] w_idx;

   // Walk from the farthest offset down so the nearest set bit wins last.
   always_comb begin
      winner = '0;
      found  = 1'b0;
      w_idx  = '0;
      for (int i = N_REQ; i >= 1; i--) begin
         w_idx = (ID_W+1)'(rr_ptr) + (ID_W+1)'(i);
         if (w_idx >= (ID_W+1)'(N_REQ)) begin
            w_idx = w_idx - (ID_W+1)'(N_REQ);
         end
         if (req[w_idx[ID_W-1:0]]) begin
            winner = w_idx[ID_W-1:0];
            found  = 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_arbiter
//  Description : Round-robin sharing of one UART transmitter; optional packet
//                lock when UART_ARB_LOCK_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int N_REQ         = 4,
   parameter int ID_W          = 2,
   parameter int START_TIMEOUT = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [N_REQ-1:0]          req,
   input  logic [c_byte_w*N_REQ-1:0] req_data,
   input  logic [N_REQ-1:0]          lock,
   input  logic                      dtr,
   input  logic                      tx_busy,
   output logic [N_REQ-1:0]          ack,
   output logic [N_REQ-1:0]          done,
   output logic [c_byte_w-1:0]       tx_data,
   output logic                      tx_start,
   output logic [ID_W-1:0]           grant_id,
   output logic                      err_drop
);

   localparam int c_cnt_w = (START_TIMEOUT < 2) ? 1 : $clog2(START_TIMEOUT);
   localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(START_TIMEOUT - 1);

   arb_state_t          r_state, w_state_nxt;
   logic [ID_W-1:0]     r_rr_ptr, w_rr_ptr_nxt;
   logic [ID_W-1:0]     r_grant_id, w_grant_id_nxt;
   logic [c_byte_w-1:0] r_tx_data, w_tx_data_nxt;
   logic [N_REQ-1:0]    r_ack, w_ack_nxt;
   logic [N_REQ-1:0]    r_done, w_done_nxt;
   logic                r_tx_start, w_tx_start_nxt;
   logic                r_err_drop, w_err_drop_nxt;
   logic [c_cnt_w-1:0]  r_cnt, w_cnt_nxt;

   logic [ID_W-1:0]     w_pick_id;
   logic                w_pick_found;
   logic [ID_W-1:0]     w_sel_id;
   logic                w_sel_valid;
   logic                w_sel_locked;
   logic [c_byte_w-1:0] w_sel_byte;

   function automatic logic [N_REQ-1:0] onehot(input logic [ID_W-1:0] idx);
      logic [N_REQ-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

   rr_picker #(
      .N_REQ (N_REQ),
      .ID_W  (ID_W)
   ) u_rr_picker (
      .req    (req),
      .rr_ptr (r_rr_ptr),
      .winner (w_pick_id),
      .found  (w_pick_found)
   );

`ifdef UART_ARB_LOCK_EN
   // Lock only applies once someone has actually owned the channel.
   logic r_owned;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_owned <= 1'b0;
      end else if (r_state == S_START) begin
         r_owned <= 1'b1;
      end
   end

   always_comb begin
      w_sel_id     = w_pick_id;
      w_sel_valid  = w_pick_found;
      w_sel_locked = 1'b0;
      if (r_owned && req[r_grant_id] && lock[r_grant_id]) begin
         w_sel_id     = r_grant_id;
         w_sel_valid  = 1'b1;
         w_sel_locked = 1'b1;
      end
   end
`else
   logic w_unused_lock;
   assign w_unused_lock = ^lock;

   always_comb begin
      w_sel_id     = w_pick_id;
      w_sel_valid  = w_pick_found;
      w_sel_locked = 1'b0;
   end
`endif

   always_comb begin
      w_sel_byte = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (w_sel_id == ID_W'(i)) begin
            w_sel_byte = req_data[i*c_byte_w +: c_byte_w];
         end
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_rr_ptr_nxt   = r_rr_ptr;
      w_grant_id_nxt = r_grant_id;
      w_tx_data_nxt  = r_tx_data;
      w_ack_nxt      = '0;
      w_done_nxt     = '0;
      w_tx_start_nxt = 1'b0;
      w_err_drop_nxt = 1'b0;
      w_cnt_nxt      = r_cnt;
      case (r_state)
         S_IDLE: begin
            if (dtr && !tx_busy && w_sel_valid) begin
               w_grant_id_nxt = w_sel_id;
               w_rr_ptr_nxt   = w_sel_locked ? r_rr_ptr : w_sel_id;
               w_tx_data_nxt  = w_sel_byte;
               w_ack_nxt      = onehot(w_sel_id);
               w_tx_start_nxt = 1'b1;
               w_state_nxt    = S_START;
            end
         end
         S_START: begin
            w_cnt_nxt   = '0;
            w_state_nxt = S_WAIT_BUSY;
         end
         S_WAIT_BUSY: begin
            if (tx_busy) begin
               w_state_nxt = S_WAIT_DONE;
            end else if (r_cnt == c_cnt_last) begin
               w_err_drop_nxt = 1'b1;
               w_state_nxt    = S_IDLE;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         S_WAIT_DONE: begin
            if (!tx_busy) begin
               w_done_nxt  = onehot(r_grant_id);
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_rr_ptr   <= ID_W'(N_REQ - 1);
         r_grant_id <= '0;
         r_tx_data  <= '0;
         r_ack      <= '0;
         r_done     <= '0;
         r_tx_start <= 1'b0;
         r_err_drop <= 1'b0;
         r_cnt      <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_rr_ptr   <= w_rr_ptr_nxt;
         r_grant_id <= w_grant_id_nxt;
         r_tx_data  <= w_tx_data_nxt;
         r_ack      <= w_ack_nxt;
         r_done     <= w_done_nxt;
         r_tx_start <= w_tx_start_nxt;
         r_err_drop <= w_err_drop_nxt;
         r_cnt      <= w_cnt_nxt;
      end
   end

   assign ack      = r_ack;
   assign done     = r_done;
   assign tx_data  = r_tx_data;
   assign tx_start = r_tx_start;
   assign grant_id = r_grant_id;
   assign err_drop = r_err_drop;

endmodule
`default_nettype wire

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the single FTDI UART transmitter among `N_REQ` byte-producing requesters. The block sits between the requesters and the transmitter's byte/start interface. It grants access round-robin, issues exactly one start per granted byte, and tracks the transmitter's busy status until the frame completes. It also reports per-requester acceptance and completion, and flags start pulses that the transmitter failed to take.

## Interface
Parameters:
- `N_REQ`, default 4: number of requesters, 2..8.
- `ID_W`, default 2: width of the grant index; must equal clog2(`N_REQ`).
- `START_TIMEOUT`, default 4: cycles allowed after `tx_start` for `tx_busy` to rise.

Ports:
- `clk`  in  1: clock.
- `reset`  in  1: synchronous, active-high reset.
- `req`  in  `N_REQ`: per-requester byte pending; level, held until `ack`.
- `req_data`  in  8*`N_REQ`: byte for requester i is at [8i+7:8i].
- `lock`  in  `N_REQ`: keep the channel for the next byte. Used only with `UART_ARB_LOCK_EN`.
- `dtr`  in  1: host data-terminal-ready. No grant is made while it is low.
- `tx_busy`  in  1: transmitter not idle (start, data or stop bits in flight).
- `ack`  out  `N_REQ`: one-cycle pulse; the byte is latched and the requester may advance its data.
- `done`  out  `N_REQ`: one-cycle pulse; the requester's frame has left the line.
- `tx_data`  out  8: byte to the transmitter; valid while `tx_start` is high.
- `tx_start`  out  1: one-cycle start/initialize pulse.
- `grant_id`  out  `ID_W`: index of the current or last owner.
- `err_drop`  out  1: one-cycle pulse when the start was not taken within `START_TIMEOUT`.

## Operation
FSM states are IDLE, START, WAIT_BUSY and WAIT_DONE.

- **IDLE**
  - Conditions: `dtr`=1, `tx_busy`=0 and any `req` bit set.
  - Winner: the first set bit searching upward from `rr_ptr`+1, with wrap at `N_REQ`-1 → 0.
  - Actions: latch `req_data[winner]`, set `grant_id` and `rr_ptr` to the winner, and go to START.
- **START**
  - `tx_start`=1, `tx_data`=latched byte and `ack[grant_id]`=1, all for exactly this cycle.
  - Then go to WAIT_BUSY and clear the timeout counter.
- **WAIT_BUSY**
  - If `tx_busy`=1, go to WAIT_DONE.
  - Otherwise the counter increments each cycle. When it reaches `START_TIMEOUT`, pulse `err_drop` and return to IDLE; no `done` is issued.
- **WAIT_DONE**
  - When `tx_busy`=0, pulse `done[grant_id]` and return to IDLE.
- **Boundary rules**
  - `dtr` falling mid-frame does not abort; the frame completes.
  - A `req` bit dropped before `ack` is simply not served.
  - A requester may raise `req` again in the same cycle as its `done`.
  - Under full load, a requester is never bypassed more than `N_REQ`-1 times.
- **Reset at any point**
  - State goes to IDLE and `rr_ptr` to `N_REQ`-1, so requester 0 has first priority.
  - `grant_id`=0, `tx_data`=0, and all pulse outputs are 0.
  - `tx_start` is never asserted during or on the cycle after reset.

## Timing
- All outputs are registered.
- Grant conditions true in IDLE at cycle T → `ack` and `tx_start` are high at T+1, and the state is WAIT_BUSY at T+2.
- `tx_busy` falling at cycle D → `done` is high at D+1, and the state is IDLE at D+1. The next grant decision is at D+1, with its start at D+2.
- Back-to-back frames therefore have a minimum gap of 2 clk between transmitter idle and the next `tx_start`.
- Timeout: with no `tx_busy`, `err_drop` pulses `START_TIMEOUT` cycles after the WAIT_BUSY entry cycle.

## Configuration
Macro: `UART_ARB_LOCK_EN`.
- **Defined**: in IDLE, if `req[grant_id]`=1 and `lock[grant_id]`=1, the owner is re-granted ahead of the round-robin search. This keeps multi-byte packets contiguous. `rr_ptr` is unchanged by a locked re-grant.
- **Undefined**: the `lock` port is present but ignored, and every grant is pure round-robin.

## Structure
- Shared package `uart_pkg`:
  - FSM state enum (2 bits).
  - Byte width constant 8.
  - The transmitter's busy-decode constant, i.e. the state encoding of the idle transmitter.
- Sub-module `rr_picker`: combinational round-robin search over `N_REQ` bits from `rr_ptr`+1, returning winner index and found flag. It is reused by later shared-resource arbiters.

## Test plan
- **Reset then single request**: `req`=4'b0100, `req_data[2]`=8'hA5, `dtr`=1 → `grant_id`=2, `tx_data`=8'hA5, `tx_start` and `ack[2]` coincide one cycle after the decision, and `done[2]` pulses one cycle after `tx_busy` falls.
- **All four requesting continuously from reset**: grant order is 0,1,2,3,0, with exactly one `tx_start` per frame.
- **`dtr`=0 with `req`=4'b0001**: no `tx_start` for 100 cycles. Raising `dtr` then gives a grant within 2 cycles.
- **`tx_busy` held low after start**: `err_drop` pulses 4 cycles after WAIT_BUSY entry, no `done`, and the FSM returns to IDLE.
- **Reset asserted in WAIT_DONE**: the cycle after reset, all outputs are 0 and the next grant goes to requester 0.
- **`UART_ARB_LOCK_EN` defined, `req`=4'b0011, `lock[0]`=1 for 3 bytes**: grants are 0,0,0, then 1 after `lock[0]` drops. With the macro undefined, grants alternate 0,1,0.
